// File: rtl/apu_frame_sequencer_if.sv
// APU frame sequencer bus bundle.
// Carries the CPU-side register write and IRQ acknowledge into the sequencer,
// and the frame strobes, IRQ level and status back out to the channel blocks.
//   master : register-bus / consumer side (drives write_en, write_data, irq_ack)
//   slave  : the frame sequencer itself
interface apu_frame_sequencer_if;
    logic       write_en;
    logic [7:0] write_data;
    logic       irq_ack;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode;
    logic [2:0] step;

    modport master (
        output write_en, write_data, irq_ack,
        input  quarter_frame, half_frame, frame_irq, mode, step
    );

    modport slave (
        input  write_en, write_data, irq_ack,
        output quarter_frame, half_frame, frame_irq, mode, step
    );
endinterface

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: free-running cycle counter that emits registered
// quarter-frame / half-frame strobes and owns the frame IRQ flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : apu_frame_sequencer_if.slave
//           in  write_en, write_data[7:0] (bit7 mode, bit6 IRQ inhibit), irq_ack
//           out quarter_frame, half_frame, frame_irq, mode, step[2:0]
module apu_frame_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned STEP1 = 7457,
    parameter int unsigned STEP2 = 14913,
    parameter int unsigned STEP3 = 22371,
    parameter int unsigned STEP4 = 29829,
    parameter int unsigned STEP5 = 37281
) (
    input  logic                   clk,
    input  logic                   reset,
    apu_frame_sequencer_if.slave   bus
);

    localparam int unsigned STEP_W = 3;

    localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

    logic [CNT_W-1:0]  cycle_count;
    logic              mode_r;
    logic              inhibit;
    logic              irq_flag;
    logic [STEP_W-1:0] step_r;
    logic              quarter_r;
    logic              half_r;

    // Step decode on the current count; S4 only counts in 4-step mode, S5 only in 5-step.
    logic at_s4_c;
    logic at_s5_c;
    logic at_term_c;
    logic hit_quarter_c;
    logic hit_half_c;
    logic irq_set_c;

    assign at_s4_c       = (cycle_count == S4) && !mode_r;
    assign at_s5_c       = (cycle_count == S5) &&  mode_r;
    assign at_term_c     = at_s4_c || at_s5_c;
    assign hit_half_c    = (cycle_count == S2) || at_term_c;
    assign hit_quarter_c = (cycle_count == S1) || (cycle_count == S3) || hit_half_c;
    assign irq_set_c     = at_s4_c && !inhibit;

    // Mode-independent low bits of the register are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^bus.write_data[5:0];

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            mode_r      <= 1'b0;
            inhibit     <= 1'b0;
            irq_flag    <= 1'b0;
            step_r      <= '0;
            quarter_r   <= 1'b0;
            half_r      <= 1'b0;
        end else if (bus.write_en) begin
            // A write restarts the sequence and drops any coincident step event.
            mode_r      <= bus.write_data[7];
            inhibit     <= bus.write_data[6];
            cycle_count <= '0;
            step_r      <= '0;
            // Selecting 5-step mode clocks the units immediately.
            quarter_r   <= bus.write_data[7];
            half_r      <= bus.write_data[7];
            if (bus.write_data[6] || bus.irq_ack) begin
                irq_flag <= 1'b0;
            end
        end else begin
            cycle_count <= at_term_c ? '0 : CNT_W'(cycle_count + 1'b1);
            quarter_r   <= hit_quarter_c;
            half_r      <= hit_half_c;
            if (at_term_c) begin
                step_r <= '0;
            end else if (hit_quarter_c) begin
                step_r <= STEP_W'(step_r + 1'b1);
            end
            // Set takes priority over a coincident acknowledge.
            if (irq_set_c) begin
                irq_flag <= 1'b1;
            end else if (bus.irq_ack) begin
                irq_flag <= 1'b0;
            end
        end
    end

    assign bus.quarter_frame = quarter_r;
    assign bus.half_frame    = half_r;
    assign bus.frame_irq     = irq_flag;
    assign bus.mode          = mode_r;
    assign bus.step          = step_r;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized bench for apu_frame_sequencer with a sequence-table reference model.
module tb_apu_frame_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    apu_frame_sequencer_if bus();

    apu_frame_sequencer #(
        .CNT_W (8),
        .STEP1 (10),
        .STEP2 (20),
        .STEP3 (30),
        .STEP4 (40),
        .STEP5 (50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Sequence tables: quarter points (last is the terminal count) and half points.
    int qpts [2][4] = '{'{10, 20, 30, 40}, '{10, 20, 30, 50}};
    int hpts [2][2] = '{'{20, 40}, '{20, 50}};

    // Model state: pos is the count the sequencer holds after the last edge.
    int pos;
    bit m_mode, m_inh, m_irq, e_q, e_h;

    function automatic bit is_quarter(int c, bit md);
        for (int i = 0; i < 4; i++) if (qpts[md][i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_half(int c, bit md);
        for (int i = 0; i < 2; i++) if (hpts[md][i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Steps completed = non-terminal step points already passed.
    function automatic int steps_done(int p, bit md);
        int n = 0;
        for (int i = 0; i < 3; i++) if (qpts[md][i] < p) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t pos=%0d: got %0h want %0h", tag, $time, pos, act, exp);
        end
    endtask

    task automatic check_all();
        check("quarter", 8'(bus.quarter_frame), 8'(e_q));
        check("half",    8'(bus.half_frame),    8'(e_h));
        check("irq",     8'(bus.frame_irq),     8'(m_irq));
        check("mode",    8'(bus.mode),          8'(m_mode));
        check("step",    8'(bus.step),          8'(steps_done(pos, m_mode)));
    endtask

    task automatic model_reset();
        pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; e_q = 0; e_h = 0;
    endtask

    // One rising edge of the reference, using the inputs currently driven.
    task automatic model_edge(input bit we, input logic [7:0] wd, input bit ack);
        int term;
        if (we) begin
            m_mode = wd[7];
            m_inh  = wd[6];
            if (wd[6] || ack) m_irq = 0;
            pos = 0;
            e_q = wd[7];
            e_h = wd[7];
        end else begin
            term = qpts[m_mode][3];
            e_q = is_quarter(pos, m_mode);
            e_h = is_half(pos, m_mode);
            if (!m_mode && pos == 40 && !m_inh) m_irq = 1;
            else if (ack) m_irq = 0;
            pos = (pos == term) ? 0 : pos + 1;
        end
    endtask

    initial begin
        bit do_rst, we, ack;
        logic [7:0] wd;

        reset = 1'b1;
        bus.write_en   = 1'b0;
        bus.write_data = 8'h00;
        bus.irq_ack    = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            // Quiet start so the first full 4-step sequences run undisturbed.
            do_rst = (i > 90) && (($urandom_range(0, 1999) == 0) ||
                     (pos == 25 && m_irq && !m_mode && $urandom_range(0, 3) == 0));
            we     = (i > 90) && (($urandom_range(0, 249) == 0) ||
                     (pos == 20 && $urandom_range(0, 19) == 0) ||
                     (m_irq && $urandom_range(0, 59) == 0));
            wd     = 8'($urandom);
            ack    = (pos == 40 && $urandom_range(0, 1) == 0) || ($urandom_range(0, 19) == 0);

            if (do_rst) begin
                bus.write_en = 1'b0;
                bus.irq_ack  = 1'b0;
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
                @(posedge clk);
                #1;
                check_all();
                @(negedge clk);
                reset = 1'b0;
            end else begin
                bus.write_en   = we;
                bus.write_data = wd;
                bus.irq_ack    = ack;
                @(posedge clk);
                model_edge(we, wd, ack);
                #1;
                check_all();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
